// File: rtl/zet_muldiv_pkg.sv
// Shared encodings and helpers for the zet_muldiv iterative multiply/divide unit.
package zet_muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_IMUL = 2'b01,
        OP_DIV  = 2'b10,
        OP_IDIV = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CHK  = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Bits needed to hold values 0..value-1
    function automatic int clog2(input int value);
        int res;
        res = 32'sd0;
        for (int v = value - 32'sd1; v > 32'sd0; v = v >> 1) begin
            res = res + 32'sd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/zet_divstep.sv
// One restoring-division step: shift a dividend bit into the partial remainder
// and subtract the divisor when it fits.
module zet_divstep
    import zet_muldiv_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] trial_s;

    // Trial subtraction of the divisor from the shifted partial remainder
    always_comb begin
        trial_s = {rem_in, bit_in};
        q_bit   = (trial_s >= {1'b0, divisor});
        if (q_bit) begin
            rem_out = WIDTH'(trial_s - {1'b0, divisor});
        end else begin
            rem_out = trial_s[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/zet_muldiv.sv
// Iterative MUL/IMUL/DIV/IDIV unit with 8086 result placement and divide exceptions.
// Optional macro ZET_MULDIV_EARLY_EN lets multiplies finish once the multiplier is exhausted.
module zet_muldiv
    import zet_muldiv_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             byteop,
    input  logic [WIDTH-1:0] a_hi,
    input  logic [WIDTH-1:0] a_lo,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             mul_ov,
    output logic             div_exc
);

    localparam int H  = WIDTH / 2;
    localparam int W2 = 2 * WIDTH;
    localparam int CW = clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] QMAX_W = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] QMAX_B = {{(H+1){1'b0}}, {(H-1){1'b1}}};

    state_e           state_r, next_state_s;
    op_e              op_r;
    logic             byte_r;
    logic [WIDTH-1:0] a_hi_r, a_lo_r, b_r;
    logic [WIDTH-1:0] hi_r, lo_r, m_r, mr_r;
    logic [CW-1:0]    cnt_r;
    logic             q_neg_r, r_neg_r, ovf_r;
    logic             busy_r, done_r, div_exc_r, mul_ov_r;
    logic [WIDTH-1:0] res_lo_r, res_hi_r;

    logic             is_div_s, is_sgn_s;
    logic [WIDTH-1:0] a_ext_s, b_ext_s, a_mag_s, b_mag_s;
    logic [W2-1:0]    dv_s, dv_mag_s;
    logic             a_neg_s, b_neg_s, d_neg_s;
    logic [WIDTH-1:0] dv_hi_s, dv_lo_s;
    logic             hi_ge_s, chk_exc_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] hi_nxt_s, lo_nxt_s, mr_nxt_s, rem_nxt_s;
    logic             q_bit_s, last_s, early_s;
    logic [W2-1:0]    prod_w_s;
    logic [WIDTH-1:0] prod_bm_s, prod_b_s;
    logic [WIDTH-1:0] quo_s, rem_s, qmax_s, quo_sg_s, rem_sg_s;
    logic [WIDTH-1:0] fix_lo_s, fix_hi_s;
    logic             fix_ov_s, fix_exc_s;

    // Operand sign extension, magnitudes and the unsigned-divide overflow precheck
    always_comb begin
        is_div_s = (op_r == OP_DIV) || (op_r == OP_IDIV);
        is_sgn_s = (op_r == OP_IMUL) || (op_r == OP_IDIV);
        if (byte_r) begin
            a_ext_s = {{H{is_sgn_s & a_lo_r[H-1]}}, a_lo_r[H-1:0]};
            b_ext_s = {{H{is_sgn_s & b_r[H-1]}}, b_r[H-1:0]};
            dv_s    = {{WIDTH{is_sgn_s & a_lo_r[WIDTH-1]}}, a_lo_r};
        end else begin
            a_ext_s = a_lo_r;
            b_ext_s = b_r;
            dv_s    = {a_hi_r, a_lo_r};
        end
        a_neg_s  = is_sgn_s & a_ext_s[WIDTH-1];
        b_neg_s  = is_sgn_s & b_ext_s[WIDTH-1];
        d_neg_s  = is_sgn_s & dv_s[W2-1];
        a_mag_s  = a_neg_s ? -a_ext_s : a_ext_s;
        b_mag_s  = b_neg_s ? -b_ext_s : b_ext_s;
        dv_mag_s = d_neg_s ? -dv_s : dv_s;
        // Byte dividend low half sits at the top of lo so it shifts out first
        if (byte_r) begin
            dv_hi_s = {{H{1'b0}}, dv_mag_s[WIDTH-1:H]};
            dv_lo_s = {dv_mag_s[H-1:0], {H{1'b0}}};
        end else begin
            dv_hi_s = dv_mag_s[W2-1:WIDTH];
            dv_lo_s = dv_mag_s[WIDTH-1:0];
        end
        hi_ge_s   = (dv_hi_s >= b_mag_s);
        chk_exc_s = is_div_s && ((b_ext_s == {WIDTH{1'b0}}) || (!is_sgn_s && hi_ge_s));
    end

    zet_divstep #(.WIDTH(WIDTH)) u_divstep (
        .rem_in  (hi_r),
        .bit_in  (lo_r[WIDTH-1]),
        .divisor (m_r),
        .rem_out (rem_nxt_s),
        .q_bit   (q_bit_s)
    );

    // One iteration: right-shift add for multiply, left-shift restore for divide
    always_comb begin
        sum_s = {1'b0, hi_r} + (mr_r[0] ? {1'b0, m_r} : {(WIDTH+1){1'b0}});
        if (is_div_s) begin
            hi_nxt_s = rem_nxt_s;
            lo_nxt_s = {lo_r[WIDTH-2:0], q_bit_s};
        end else begin
            {hi_nxt_s, lo_nxt_s} = {sum_s, lo_r[WIDTH-1:1]};
        end
        mr_nxt_s = mr_r >> 1;
        last_s   = (cnt_r == CW'(1));
`ifdef ZET_MULDIV_EARLY_EN
        early_s  = !is_div_s && (mr_nxt_s == {WIDTH{1'b0}}) && !last_s;
`else
        early_s  = 1'b0;
`endif
    end

    // Sign correction, result placement and overflow checks applied in FIX
    always_comb begin
        prod_w_s  = q_neg_r ? -{hi_r, lo_r} : {hi_r, lo_r};
        prod_bm_s = {hi_r[H-1:0], lo_r[WIDTH-1:H]};
        prod_b_s  = q_neg_r ? -prod_bm_s : prod_bm_s;
        if (byte_r) begin
            quo_s  = {{H{1'b0}}, lo_r[H-1:0]};
            rem_s  = {{H{1'b0}}, hi_r[H-1:0]};
            qmax_s = QMAX_B;
        end else begin
            quo_s  = lo_r;
            rem_s  = hi_r;
            qmax_s = QMAX_W;
        end
        quo_sg_s  = q_neg_r ? -quo_s : quo_s;
        rem_sg_s  = r_neg_r ? -rem_s : rem_s;
        fix_exc_s = is_div_s && is_sgn_s && (ovf_r || (quo_s > qmax_s));
        if (is_div_s) begin
            fix_lo_s = byte_r ? {rem_sg_s[H-1:0], quo_sg_s[H-1:0]} : quo_sg_s;
            fix_hi_s = byte_r ? {WIDTH{1'b0}} : rem_sg_s;
            fix_ov_s = mul_ov_r;
        end else if (byte_r) begin
            fix_lo_s = prod_b_s;
            fix_hi_s = {WIDTH{1'b0}};
            fix_ov_s = is_sgn_s ? (prod_b_s[WIDTH-1:H] != {H{prod_b_s[H-1]}})
                                : (prod_b_s[WIDTH-1:H] != {H{1'b0}});
        end else begin
            {fix_hi_s, fix_lo_s} = prod_w_s;
            fix_ov_s = is_sgn_s ? (prod_w_s[W2-1:WIDTH] != {WIDTH{prod_w_s[WIDTH-1]}})
                                : (prod_w_s[W2-1:WIDTH] != {WIDTH{1'b0}});
        end
    end

    // Next-state selection
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: if (start) next_state_s = ST_CHK; else next_state_s = ST_IDLE;
            ST_CHK:  if (chk_exc_s) next_state_s = ST_DONE; else next_state_s = ST_ITER;
            ST_ITER: if (last_s || early_s) next_state_s = ST_FIX; else next_state_s = ST_ITER;
            ST_FIX:  next_state_s = ST_DONE;
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Handshake flags are decoded from the next state so they leave a flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            div_exc_r <= 1'b0;
        end else begin
            busy_r    <= (next_state_s == ST_CHK) || (next_state_s == ST_ITER) ||
                         (next_state_s == ST_FIX);
            done_r    <= (next_state_s == ST_DONE);
            div_exc_r <= ((state_r == ST_CHK) && chk_exc_s) || ((state_r == ST_FIX) && fix_exc_s);
        end
    end

    // Operand latch, iteration datapath and result write-back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r     <= OP_MUL;
            byte_r   <= 1'b0;
            a_hi_r   <= {WIDTH{1'b0}};
            a_lo_r   <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            m_r      <= {WIDTH{1'b0}};
            mr_r     <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            q_neg_r  <= 1'b0;
            r_neg_r  <= 1'b0;
            ovf_r    <= 1'b0;
            res_lo_r <= {WIDTH{1'b0}};
            res_hi_r <= {WIDTH{1'b0}};
            mul_ov_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        op_r   <= op_e'(op);
                        byte_r <= byteop;
                        a_hi_r <= a_hi;
                        a_lo_r <= a_lo;
                        b_r    <= b;
                    end
                end
                ST_CHK: begin
                    cnt_r <= byte_r ? CW'(H) : CW'(WIDTH);
                    if (is_div_s) begin
                        hi_r    <= dv_hi_s;
                        lo_r    <= dv_lo_s;
                        m_r     <= b_mag_s;
                        mr_r    <= {WIDTH{1'b0}};
                        q_neg_r <= d_neg_s ^ b_neg_s;
                        r_neg_r <= d_neg_s;
                        ovf_r   <= is_sgn_s & hi_ge_s;
                    end else begin
                        hi_r    <= {WIDTH{1'b0}};
                        lo_r    <= {WIDTH{1'b0}};
                        m_r     <= a_mag_s;
                        mr_r    <= b_mag_s;
                        q_neg_r <= a_neg_s ^ b_neg_s;
                        r_neg_r <= 1'b0;
                        ovf_r   <= 1'b0;
                    end
                end
                ST_ITER: begin
                    cnt_r <= cnt_r - CW'(1);
                    mr_r  <= mr_nxt_s;
`ifdef ZET_MULDIV_EARLY_EN
                    // Skipped steps would only shift, so apply them all at once
                    if (early_s) begin
                        {hi_r, lo_r} <= {hi_nxt_s, lo_nxt_s} >> (cnt_r - CW'(1));
                    end else begin
                        {hi_r, lo_r} <= {hi_nxt_s, lo_nxt_s};
                    end
`else
                    hi_r <= hi_nxt_s;
                    lo_r <= lo_nxt_s;
`endif
                end
                ST_FIX: begin
                    if (!fix_exc_s) begin
                        res_lo_r <= fix_lo_s;
                        res_hi_r <= fix_hi_s;
                        mul_ov_r <= fix_ov_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign div_exc = div_exc_r;
    assign res_lo  = res_lo_r;
    assign res_hi  = res_hi_r;
    assign mul_ov  = mul_ov_r;

endmodule

// File: tb/tb_zet_muldiv.sv
// Self-checking bench for zet_muldiv (WIDTH=16, default build) against an arithmetic model.
module tb_zet_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic        byteop;
    logic [15:0] a_hi, a_lo, b;
    logic        busy, done, mul_ov, div_exc;
    logic [15:0] res_lo, res_hi;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [15:0] exp_lo = 16'h0000;
    logic [15:0] exp_hi = 16'h0000;
    logic        exp_ov = 1'b0;

    zet_muldiv #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .byteop(byteop),
        .a_hi(a_hi), .a_lo(a_lo), .b(b), .busy(busy), .done(done),
        .res_lo(res_lo), .res_hi(res_hi), .mul_ov(mul_ov), .div_exc(div_exc)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the 8086 rules; updates exp_* and returns exc/latency
    task automatic model(input logic [1:0] o, input logic bo, input logic [15:0] ah,
                         input logic [15:0] al, input logic [15:0] bb,
                         output logic exc, output int lat);
        longint x, y, p, q, r, smax, umax;
        logic   sgn;
        sgn  = o[0];
        exc  = 1'b0;
        lat  = bo ? 11 : 19;
        smax = bo ? 127 : 32767;
        umax = bo ? 255 : 65535;
        if (!o[1]) begin
            if (bo) begin
                x = sgn ? longint'($signed(al[7:0])) : longint'(al[7:0]);
                y = sgn ? longint'($signed(bb[7:0])) : longint'(bb[7:0]);
            end else begin
                x = sgn ? longint'($signed(al)) : longint'(al);
                y = sgn ? longint'($signed(bb)) : longint'(bb);
            end
            p = x * y;
            if (bo) begin
                exp_lo = p[15:0];
                exp_hi = 16'h0000;
                exp_ov = sgn ? (p < -128 || p > 127) : (p > 255);
            end else begin
                exp_lo = p[15:0];
                exp_hi = p[31:16];
                exp_ov = sgn ? (p < -32768 || p > 32767) : (p > 65535);
            end
        end else begin
            if (bo) begin
                x = sgn ? longint'($signed(al)) : longint'(al);
                y = sgn ? longint'($signed(bb[7:0])) : longint'(bb[7:0]);
            end else begin
                x = sgn ? longint'($signed({ah, al})) : longint'({ah, al});
                y = sgn ? longint'($signed(bb)) : longint'(bb);
            end
            if (y == 0) begin
                exc = 1'b1;
                lat = 2;
            end else begin
                q = x / y;
                r = x % y;
                if (!sgn && q > umax) begin
                    exc = 1'b1;
                    lat = 2;
                end else if (sgn && (q > smax || q < -smax)) begin
                    exc = 1'b1;
                end else if (bo) begin
                    exp_lo = {r[7:0], q[7:0]};
                    exp_hi = 16'h0000;
                end else begin
                    exp_lo = q[15:0];
                    exp_hi = r[15:0];
                end
            end
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic bo, input logic [15:0] ah,
                          input logic [15:0] al, input logic [15:0] bb,
                          input bit poke, input string tag);
        logic e_exc;
        int   e_lat, cyc;
        bit   seen;
        model(o, bo, ah, al, bb, e_exc, e_lat);
        cyc = 0;
        @(negedge clk);
        while ((busy || done) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        start = 1'b1; op = o; byteop = bo; a_hi = ah; a_lo = al; b = bb;
        @(posedge clk); #1;
        start = 1'b0;
        op = 2'($urandom); byteop = 1'($urandom);
        a_hi = 16'($urandom); a_lo = 16'($urandom); b = 16'($urandom);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL %s busy_after_accept: got %b want 1", tag, busy);
        end
        cyc = 0; seen = 0;
        while (!seen && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (done === 1'b1) seen = 1;
            start = poke && !seen;
            if (start) begin
                op = 2'($urandom); a_lo = 16'($urandom); b = 16'($urandom);
            end
        end
        start = 1'b0;
        n_cmp++;
        if (!seen) begin
            n_fail++; $display("FAIL %s timeout: no done within %0d cycles", tag, cyc);
        end else begin
            n_cmp++;
            if (cyc + 1 != e_lat) begin
                n_fail++; $display("FAIL %s latency: got %0d want %0d", tag, cyc + 1, e_lat);
            end
            n_cmp++;
            if (div_exc !== e_exc) begin
                n_fail++; $display("FAIL %s div_exc: got %b want %b", tag, div_exc, e_exc);
            end
            n_cmp++;
            if (res_lo !== exp_lo || res_hi !== exp_hi) begin
                n_fail++;
                $display("FAIL %s result: got %h:%h want %h:%h", tag, res_hi, res_lo, exp_hi, exp_lo);
            end
            n_cmp++;
            if (mul_ov !== exp_ov) begin
                n_fail++; $display("FAIL %s mul_ov: got %b want %b", tag, mul_ov, exp_ov);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (done !== 1'b0 || div_exc !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL %s after_done: got done=%b exc=%b busy=%b want 0 0 0", tag, done, div_exc, busy);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 2'b00; byteop = 1'b0;
        a_hi = 16'h0000; a_lo = 16'h0000; b = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, mul_ov, div_exc} !== 4'b0000 || res_lo !== 16'h0000 || res_hi !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b ov=%b exc=%b res=%h:%h want all 0",
                     busy, done, mul_ov, div_exc, res_hi, res_lo);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_plan();
        run_op(2'b00, 1'b0, 16'h0000, 16'h1234, 16'h5678, 1'b0, "plan_mul");
        n_cmp++;
        if (res_hi !== 16'h0626 || res_lo !== 16'h0060 || mul_ov !== 1'b1) begin
            n_fail++; $display("FAIL plan_mul_const: got %h:%h ov=%b want 0626:0060 ov=1", res_hi, res_lo, mul_ov);
        end
        run_op(2'b11, 1'b0, 16'hFFFF, 16'hFFF9, 16'h0002, 1'b0, "plan_idiv");
        n_cmp++;
        if (res_lo !== 16'hFFFD || res_hi !== 16'hFFFF) begin
            n_fail++; $display("FAIL plan_idiv_const: got %h:%h want FFFF:FFFD", res_hi, res_lo);
        end
        run_op(2'b10, 1'b0, 16'h1111, 16'h2222, 16'h0000, 1'b0, "plan_div0");
        run_op(2'b10, 1'b1, 16'h0000, 16'h0100, 16'h0001, 1'b0, "plan_bdiv_ovf");
        run_op(2'b10, 1'b1, 16'h0000, 16'h0107, 16'h0002, 1'b0, "plan_bdiv");
        n_cmp++;
        if (res_lo !== 16'h0183) begin
            n_fail++; $display("FAIL plan_bdiv_const: got %h want 0183", res_lo);
        end
        run_op(2'b01, 1'b1, 16'h0000, 16'h00FE, 16'h0003, 1'b0, "plan_bimul");
        run_op(2'b11, 1'b0, 16'hFFFF, 16'h8000, 16'h0001, 1'b0, "idiv_min_quot");
        run_op(2'b01, 1'b0, 16'h0000, 16'h8000, 16'hFFFF, 1'b0, "imul_min");
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic        bo;
        logic [15:0] ah, al, bb;
        for (int i = 0; i < 60; i++) begin
            o  = 2'($urandom);
            bo = 1'($urandom);
            ah = 16'($urandom);
            al = 16'($urandom);
            bb = 16'($urandom);
            if (($urandom % 2) == 0) begin
                if (bo) al[15:8] = (bb[7:0] == 8'h00) ? 8'h00 : 8'($urandom_range(bb[7:0] - 1, 0));
                else    ah = (bb == 16'h0000) ? 16'h0000 : 16'($urandom_range(bb - 1, 0));
            end
            run_op(o, bo, ah, al, bb, 1'b0, "random");
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            run_op(2'(i % 4), 1'(i / 4), 16'h0003, 16'($urandom), 16'($urandom_range(200, 5)),
                   1'b1, "start_while_busy");
        end
    endtask

    task automatic test_reset_abort();
        bit seen;
        run_op(2'b00, 1'b0, 16'h0000, 16'h1234, 16'h5678, 1'b0, "pre_abort_mul");
        @(negedge clk);
        start = 1'b1; op = 2'b10; byteop = 1'b0; a_hi = 16'h0000; a_lo = 16'd1000; b = 16'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, mul_ov, div_exc} !== 4'b0000 || res_lo !== 16'h0000 || res_hi !== 16'h0000) begin
            n_fail++;
            $display("FAIL abort_reset: got busy=%b done=%b ov=%b exc=%b res=%h:%h want all 0",
                     busy, done, mul_ov, div_exc, res_hi, res_lo);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_lo = 16'h0000; exp_hi = 16'h0000; exp_ov = 1'b0;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) seen = 1;
        end
        n_cmp++;
        if (seen) begin
            n_fail++; $display("FAIL abort_no_done: got activity after reset want none");
        end
        run_op(2'b00, 1'b0, 16'h0000, 16'h0003, 16'h0004, 1'b0, "post_abort_mul");
        n_cmp++;
        if (res_lo !== 16'h000C) begin
            n_fail++; $display("FAIL post_abort_const: got %h want 000C", res_lo);
        end
    endtask

    initial begin
        test_reset();
        test_plan();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
